// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: operand/product sequencer for the array multiplier core.
// Ports: clk, rst_n, ena, in_valid/in_data/in_ready, mul_a/mul_b/mul_p,
//   out_valid/out_data/out_ready, busy.
// Optional MULT_SEQ_ACCUM_EN: adds acc_clr/acc_ovf.
// With it, capture accumulates into out_data.
module mult_seq_ctrl #(
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           in_valid,
  input  logic [2*W-1:0] in_data,
  output logic           in_ready,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           out_valid,
  output logic [2*W-1:0] out_data,
  input  logic           out_ready,
  output logic           busy
`ifdef MULT_SEQ_ACCUM_EN
  ,
  input  logic           acc_clr,
  output logic           acc_ovf
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign in_ready = (state == IDLE) && ena;

`ifdef MULT_SEQ_ACCUM_EN
  // Extra top bit is the carry out of the accumulation.
  logic [2*W:0] sum;
  assign sum = {1'b0, out_data} + {1'b0, mul_p};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef MULT_SEQ_ACCUM_EN
      acc_ovf   <= 1'b0;
`endif
    end else if (ena) begin
      unique case (state)
        IDLE: begin
`ifdef MULT_SEQ_ACCUM_EN
          if (acc_clr) begin
            out_data <= '0;
            acc_ovf  <= 1'b0;
          end
`endif
          if (in_valid) begin
            mul_a <= in_data[2*W-1:W];
            mul_b <= in_data[W-1:0];
            cnt   <= CW'(SETTLE - 1);
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
`ifdef MULT_SEQ_ACCUM_EN
            out_data <= sum[2*W-1:0];
            if (sum[2*W]) acc_ovf <= 1'b1;
`else
            out_data <= mul_p;
`endif
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer for the structural array multiplier datapath. It accepts an operand pair over a valid/ready input, drives registered operands into the combinational multiplier and waits a fixed settle time. It then captures the product and presents it on a valid/ready output. It sits between the tt_um top-level pin mapping (ui_in/uo_out) and the multiplier core, so the core only ever sees stable operands and the pins only ever see a registered product.

Parameters:
W, 4, operand width in bits; product width is 2W.
SETTLE, 2, cycles (>=1) between operand launch and product capture; covers array ripple delay.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; low freezes the FSM
in_valid  input  1  operand pair offered
in_data  input  2W  {A[2W-1:W], B[W-1:0]}
in_ready  output  1  controller can accept an operand pair
mul_a  output  W  registered operand A to multiplier
mul_b  output  W  registered operand B to multiplier
mul_p  input  2W  combinational product from multiplier
out_valid  output  1  product available
out_data  output  2W  registered product
out_ready  input  1  consumer accepts product
busy  output  1  high in WAIT or HOLD

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n. The clock port is clk.
- Reset values: state=IDLE, mul_a=0, mul_b=0, out_data=0, out_valid=0, busy=0, and the counter is 0. in_ready is combinational: (state==IDLE)&&ena, so it is 1 after reset when ena=1.
- The FSM has three states: IDLE, WAIT and HOLD.
- IDLE, on accept (in_valid && in_ready at edge t0):
  - mul_a <= in_data[2W-1:W] and mul_b <= in_data[W-1:0].
  - cnt <= SETTLE-1.
  - Next state is WAIT.
- WAIT:
  - If cnt==0: out_data <= mul_p, out_valid <= 1, next state HOLD.
  - Otherwise cnt <= cnt-1.
  - Capture therefore occurs at edge t0+SETTLE. out_valid is first seen high in the cycle after that edge.
- HOLD:
  - out_data and out_valid hold until out_ready=1 at an edge. At that edge out_valid <= 0 and the next state is IDLE.
  - out_data keeps its last value after the handshake; it is not cleared.
- Pipelining: one transaction in flight, no overlap. in_ready is 0 throughout WAIT and HOLD, so in_valid in those states is ignored and not queued. Minimum issue interval is SETTLE+2 cycles with out_ready tied high.
- mul_a and mul_b change only on accept and remain stable through WAIT and HOLD.
- ena=0: no state, counter or register updates in any state. Outputs hold their values, and in_ready=0.
- Reset mid-operation (WAIT or HOLD): return immediately to reset values. A pending product is lost and no out_valid pulse occurs.
- The counter is wide enough for SETTLE-1 (clog2, minimum 1 bit).

Optional Feature:
Macro name: MULT_SEQ_ACCUM_EN.
- When defined:
  - Adds input acc_clr (1) and output acc_ovf (1).
  - At capture: out_data <= out_data + mul_p, modulo 2^(2W). acc_ovf is set sticky if the addition carries out of bit 2W-1.
  - acc_clr=1 at an edge while in IDLE clears out_data and acc_ovf to 0. It has priority over a simultaneous accept, which still proceeds from the cleared value.
  - acc_clr is ignored in WAIT and HOLD.
  - Both new registers reset to 0.
- When undefined: the ports are absent, and capture is a plain load out_data <= mul_p.

Test Plan:
1. Reset then single multiply (W=4, SETTLE=2, ena=1, out_ready=1):
   - Stimulus: in_data=0x79 accepted at edge 0.
   - Response: mul_a=7, mul_b=9 after edge 0; out_valid high after edge 2 with out_data=0x3F; IDLE after edge 3.
2. Boundary operands:
   - Stimulus: 0xFF, then 0x0A.
   - Response: out_data=0xE1, then 0x00; in_ready=0 during WAIT/HOLD.
3. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after capture of 0x34.
   - Response: out_data=0x0C and out_valid stay stable; in_valid with 0x22 offered during HOLD is not accepted; after out_ready=1, the next accept yields 0x04.
4. ena gating:
   - Stimulus: drop ena for 3 cycles in WAIT.
   - Response: capture is delayed by exactly 3 cycles with the correct product; in_ready=0 while ena=0.
5. Reset mid-WAIT:
   - Stimulus: assert rst_n=0 asynchronously between clock edges.
   - Response: outputs go to reset values immediately with no out_valid pulse; the next operand pair 0x23 yields 0x06.
6. MULT_SEQ_ACCUM_EN:
   - Stimulus: 0x34 then 0x56.
   - Response: out_data=0x0C then 0x2A, acc_ovf=0. Then acc_clr, 0xFF and 0xFF gives 0xE1 then 0xC2 with acc_ovf=1; acc_clr returns both to 0.
